// File: rtl/apb_master.sv
// APB requester: takes one command at a time from a valid/ready port and runs the
// SETUP/ACCESS sequence. It returns read data and a timeout status on a one-cycle strobe.
module apb_master #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a command is taken on a rising edge where cmd_valid and
    // cmd_ready are both 1; rsp_valid is a single-cycle strobe with no back-pressure.

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_psel, w_psel_nxt;
    logic              r_penable, w_penable_nxt;
    logic              r_pwrite, w_pwrite_nxt;
    logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_timeout;

    assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LIM);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_state_nxt  = SETUP;
                    w_psel_nxt   = 1'b1;
                    w_pwrite_nxt = cmd_write;
                    w_paddr_nxt  = cmd_addr;
                    w_pwdata_nxt = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = CNT_W'(1);
            end
            ACCESS: begin
                // pready takes priority over the timeout limit in the same cycle
                if (pready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
                    w_cnt_nxt       = '0;
                end else if (w_timeout) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_cnt_nxt       = '0;
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                    if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready   = (r_state == IDLE) && !preset;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a behavioural APB slave with per-transfer wait states,
// a memory reference model, and an expected-response queue checked by a monitor.
module tb_apb_master;
  localparam int TO = 4;
  localparam int HANG = -1;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [15:0] prdata = '0;
  logic pready = 1'b0;
  logic cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
  logic [15:0] rsp_rdata, paddr, pwdata;
  logic [1:0] dbg_state;

  apb_master #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .o_dbg_state(dbg_state)
  );

  // clock / reset-sample / cycle count
  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic rst_q = 1'b1;

  logic [48:0] exp_q[$];   // {response cycle, err, rdata}
  logic [32:0] bus_q[$];   // {pwrite, paddr, pwdata} expected in SETUP
  int ws_q[$];             // wait states per transfer, HANG = never ready
  logic [15:0] ref_mem[int];
  logic [15:0] slv_mem[int];
  logic [16:0] last_rsp = '0;
  logic [32:0] prev_bus = '0;
  logic prev_psel = 1'b0;
  logic prev_penable = 1'b0;
  int cur_ws = 0;
  int acc = 0;
  logic [15:0] addrs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
  endfunction

  function automatic logic [15:0] slv_rd(input logic [15:0] a);
    return slv_mem.exists(int'(a)) ? slv_mem[int'(a)] : 16'h0;
  endfunction

  always @(posedge pclk) begin
    cyc++;
    rst_q = preset;
    if (!preset && psel && penable && pready && pwrite) slv_mem[int'(paddr)] = pwdata;
  end

  // behavioural APB slave; pready is randomized outside ACCESS
  always @(negedge pclk) begin
    if (psel && !penable) begin
      cur_ws = (ws_q.size() != 0) ? ws_q.pop_front() : 0;
      acc = 0;
      pready = 1'($urandom_range(0, 1));
      prdata = 16'($urandom);
    end else if (psel && penable) begin
      pready = (cur_ws != HANG) && (acc >= cur_ws);
      prdata = (pready && !pwrite) ? slv_rd(paddr) : 16'($urandom);
      acc++;
    end else begin
      pready = 1'($urandom_range(0, 1));
      prdata = 16'($urandom);
    end
  end

  // monitor / scoreboard
  always @(negedge pclk) begin
    logic [48:0] e;
    logic [32:0] b;
    #1;
    chk("cmd_ready", cmd_ready, !psel && !preset);
    if (rst_q) begin
      chk("rst_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err}, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rdata", rsp_rdata, 0);
      last_rsp = '0;
    end else begin
      if (rsp_valid) begin
        chk("rsp_psel", {psel, penable}, 0);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", cyc, e[48:17]);
          chk("rsp_err", rsp_err, e[16]);
          chk("rsp_rdata", rsp_rdata, e[15:0]);
        end
        last_rsp = {rsp_err, rsp_rdata};
      end else begin
        chk("rsp_hold", {rsp_err, rsp_rdata}, last_rsp);
      end
      chk("penable_wo_psel", penable && !psel, 0);
      if (psel && !penable) begin
        if (bus_q.size() == 0) chk("setup_unexpected", 1, 0);
        else begin
          b = bus_q.pop_front();
          chk("setup_bus", {pwrite, paddr, pwdata}, b);
        end
      end else begin
        chk("bus_stable", {pwrite, paddr, pwdata}, prev_bus);
      end
      if (prev_psel && !prev_penable) chk("setup_to_access", {psel, penable}, 2'b11);
    end
    prev_bus = {pwrite, paddr, pwdata};
    prev_psel = psel;
    prev_penable = penable;
  end

  // driver tasks
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input int ws, output int hs);
    int guard;
    int lat;
    logic err;
    logic [15:0] rd;
    guard = 0;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    #1;
    while (!cmd_ready && guard < 100) begin
      @(negedge pclk);
      #1;
      guard++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 1, 0);
      cmd_valid = 1'b0;
      hs = -1;
      return;
    end
    hs = cyc;
    if (ws == HANG) begin
      lat = 2 + TO;
      err = 1'b1;
      rd = 16'h0;
    end else begin
      lat = 3 + ws;
      err = 1'b0;
      rd = w ? 16'h0 : ref_rd(a);
      if (w) ref_mem[int'(a)] = d;
    end
    exp_q.push_back({32'(hs + lat), err, rd});
    bus_q.push_back({w, a, w ? d : 16'h0});
    ws_q.push_back(ws);
    @(posedge pclk);
  endtask

  task automatic idle();
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr = 16'($urandom);
    cmd_wdata = 16'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge pclk);
      g++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int hs, h1, h2, h3, ws;
    logic w;
    repeat (3) @(negedge pclk);
    preset = 1'b0;

    // directed transfers
    send(1'b1, 16'h0123, 16'hBEEF, 0, hs); idle(); drain();
    send(1'b0, 16'h0123, 16'h5A5A, 2, hs); idle(); drain();
    send(1'b0, 16'h0200, 16'h0000, HANG, hs); idle(); drain();
    send(1'b1, 16'h0300, 16'h1234, HANG, hs); idle(); drain();
    send(1'b0, 16'h0300, 16'h0000, 0, hs); idle(); drain();
    send(1'b0, 16'h0123, 16'h0000, 3, hs); idle(); drain();

    // three queued commands with cmd_valid held high
    send(1'b1, 16'h0400, 16'hCAFE, 0, h1);
    send(1'b0, 16'h0123, 16'hFFFF, 0, h2);
    send(1'b1, 16'h0401, 16'hF00D, 0, h3);
    idle();
    chk("b2b_period_1", h2 - h1, 3);
    chk("b2b_period_2", h3 - h2, 3);
    drain();

    // reset during the second ACCESS cycle of a read
    send(1'b0, 16'h0400, 16'h0000, 3, hs);
    idle();
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    void'(exp_q.pop_back());
    @(negedge pclk);
    preset = 1'b0;
    #2;
    chk("rst_abort_bus", {psel, penable}, 0);
    chk("rst_abort_ready", cmd_ready, 1);
    repeat (6) @(negedge pclk);

    // random writes then read-back, wait states 0..3
    for (int i = 0; i < 16; i++) begin
      addrs[i] = 16'($urandom);
      send(1'b1, addrs[i], 16'($urandom), $urandom_range(0, 3), hs);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle(); drain();
    for (int i = 15; i >= 0; i--) begin
      send(1'b0, addrs[i], 16'($urandom), $urandom_range(0, 3), hs);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle(); drain();

    // random mix including occasional timeouts
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      ws = ($urandom_range(0, 7) == 0) ? HANG : int'($urandom_range(0, 3));
      send(w, addrs[$urandom_range(0, 15)], 16'($urandom), ws, hs);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle(); drain();

    chk("queues_empty", exp_q.size() + bus_q.size() + ws_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
